nco_iq_mixer: RTL
=================

NCO_IQ_MIXER -- requirements
Module: nco_iq_mixer

Interface
REQ-001 SHALL have parameter MPR, default 32, meaning NCO sine/cosine word width (signed two's complement).
REQ-002 SHALL have parameter DW, default 16, meaning input sample width (signed).
REQ-003 SHALL have parameter OW, default 16, meaning I/Q output width (signed); OW <= DW.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic rising-edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 clken  in  1  global clock enable; all state holds when low.
REQ-007 in_valid  in  1  sample_i valid this cycle.
REQ-008 sample_i  in  DW  signed input sample.
REQ-009 fsin_i  in  MPR  NCO sine word.
REQ-010 fcos_i  in  MPR  NCO cosine word.
REQ-011 nco_valid  in  1  NCO out_valid.
REQ-012 sat_clr  in  1  clears sticky saturation flag.
REQ-013 i_o  out  OW  in-phase result.
REQ-014 q_o  out  OW  quadrature result.
REQ-015 out_valid  out  1  i_o/q_o valid, one-cycle pulse per accepted sample.
REQ-016 sat_flag  out  1  sticky: any output saturated since last clear.
REQ-017 drop_cnt  out  16  count of samples discarded while NCO not valid.

Function
REQ-018 A sample SHALL be accepted only in a cycle where clken=1, in_valid=1 and nco_valid=1.
REQ-019 When clken=1, in_valid=1, nco_valid=0, drop_cnt SHALL increment by 1, saturating at 0xFFFF.
REQ-020 Stage 1 SHALL register sample_i, fsin_i, fcos_i and a valid bit on acceptance.
REQ-021 Stage 2 SHALL form full-precision products P_I = sample*fcos and P_Q = -(sample*fsin), each DW+MPR+1 bits signed, no intermediate truncation.
REQ-022 Stage 3 SHALL scale by S = MPR-1+DW-OW: result = (P + 2^(S-1)) arithmetic-shifted right by S (round half toward +inf).
REQ-023 Stage 3 SHALL saturate each result to [-2^(OW-1), 2^(OW-1)-1] and register it into i_o/q_o.
REQ-024 Latency SHALL be exactly 3 clken-enabled cycles from acceptance to out_valid=1.
REQ-025 out_valid SHALL be 1 only in the clken=1 cycle in which new results are loaded, otherwise 0; i_o/q_o hold last value.
REQ-026 When clken=0 the pipeline, valid bits, drop_cnt and sat_flag SHALL hold; out_valid SHALL be 0.
REQ-027 sat_flag SHALL set when either channel saturates at stage 3 with valid; sat_clr SHALL clear it (sat_clr acts regardless of clken).
REQ-028 Simultaneous sat_clr and new saturation SHALL leave sat_flag=1 (set wins).
REQ-029 Back-to-back accepted samples SHALL produce back-to-back out_valid pulses, no bubbles, throughput 1 sample/cycle.
REQ-030 nco_valid dropping mid-stream SHALL not flush samples already in the pipeline.

Reset
REQ-031 On reset_n=0 all pipeline valid bits, out_valid, sat_flag SHALL be 0; i_o, q_o, drop_cnt SHALL be 0; pipeline data registers SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight samples; no out_valid pulse SHALL appear for them after release.

Structure
REQ-033 Default widths (MPR, DW, OW) and the derived shift S SHALL live in shared package nco_mix_pkg.
REQ-034 Round-and-saturate SHALL be one sub-module, nco_round_sat, instantiated once per channel, parameterised by input width, S and OW.

Verification
REQ-035 sample=16384, fcos=0x7FFFFFFF, fsin=0, continuous valid -> i_o=16384, q_o=0, out_valid 3 cycles after acceptance.
REQ-036 sample=-32768, fcos=0x80000000, fsin=0x80000000 -> i_o=32767 (saturated), q_o=-32768, sat_flag=1; sat_clr pulse -> sat_flag=0.
REQ-037 in_valid=1 for 10 cycles with nco_valid=0 -> drop_cnt=10, no out_valid; drop_cnt at 0xFFFF stays 0xFFFF.
REQ-038 8 consecutive samples with clken toggling 1010... -> 8 outputs in order, each after 3 enabled cycles, out_valid never high while clken=0.
REQ-039 reset_n pulsed low with 2 samples in flight -> all outputs 0, no out_valid for those samples after release.
REQ-040 Random samples and sin/cos words, 10000 cycles -> outputs match bit-exact reference model of REQ-021..023.

Source files
------------

// File: rtl/nco_mix_pkg.sv
// Shared widths for the NCO I/Q mixer and the output scaling shift derived from them.
// S = MPR-1+DW-OW aligns the product binary point with the OW-bit output.
package nco_mix_pkg;

  localparam int unsigned MPR_DEF = 32;
  localparam int unsigned DW_DEF  = 16;
  localparam int unsigned OW_DEF  = 16;

  // Scaling shift that maps a full-precision product onto the OW-bit output grid.
  function automatic int unsigned shift_of(input int unsigned mpr,
                                           input int unsigned dw,
                                           input int unsigned ow);
    return mpr - 1 + dw - ow;
  endfunction

  localparam int unsigned S_DEF = shift_of(MPR_DEF, DW_DEF, OW_DEF);

endpackage

// File: rtl/nco_round_sat.sv
// Round-half-up, arithmetic right shift by S, then saturate to a signed OW-bit range.
// Purely combinational; the caller registers res_c/sat_c.
//   din   : signed IW-bit full-precision value
//   res_c : signed OW-bit rounded and clipped result
//   sat_c : high when res_c was clipped
// S must be at least 1.
module nco_round_sat #(
  parameter int unsigned IW = 49,
  parameter int unsigned S  = 31,
  parameter int unsigned OW = 16
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] res_c,
  output logic                 sat_c
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int unsigned SW = IW + 1;

  localparam logic signed [SW-1:0] RND  = SW'(1) <<< (S - 1);
  localparam logic signed [SW-1:0] MAXV = (SW'(1) <<< (OW - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MINV = -(SW'(1) <<< (OW - 1));

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shr;

  always_comb begin
    sum   = SW'(din) + RND;
    shr   = sum >>> S;
    res_c = OW'(shr);
    sat_c = 1'b0;
    if (shr > MAXV) begin
      res_c = OW'(MAXV);
      sat_c = 1'b1;
    end else if (shr < MINV) begin
      res_c = OW'(MINV);
      sat_c = 1'b1;
    end
  end

endmodule

// File: rtl/nco_iq_mixer.sv
// Three-stage NCO I/Q mixer: I = round(sample*cos), Q = round(-(sample*sin)),
// scaled and saturated to OW bits.
//   clk, reset_n        : clock, async active-low reset
//   clken               : global enable; all state holds while low
//   in_valid, sample_i  : input sample stream
//   fsin_i, fcos_i      : NCO sine/cosine words, nco_valid marks them usable
//   sat_clr             : clears sat_flag (independent of clken)
//   i_o, q_o, out_valid : results and their one-enabled-cycle valid pulse
//   sat_flag            : sticky saturation indicator
//   drop_cnt            : saturating count of samples dropped for lack of NCO
module nco_iq_mixer
  import nco_mix_pkg::*;
#(
  parameter int unsigned MPR = MPR_DEF,
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned OW  = OW_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  in_valid,
  input  logic signed [DW-1:0]  sample_i,
  input  logic signed [MPR-1:0] fsin_i,
  input  logic signed [MPR-1:0] fcos_i,
  input  logic                  nco_valid,
  input  logic                  sat_clr,
  output logic signed [OW-1:0]  i_o,
  output logic signed [OW-1:0]  q_o,
  output logic                  out_valid,
  output logic                  sat_flag,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned PW = DW + MPR + 1;
  localparam int unsigned S  = shift_of(MPR, DW, OW);
  localparam int unsigned CW = 16;

  logic                  accept_c;
  logic                  drop_c;

  logic                  s1_vld_q, s1_vld_d;
  logic signed [DW-1:0]  s1_smp_q, s1_smp_d;
  logic signed [MPR-1:0] s1_sin_q, s1_sin_d;
  logic signed [MPR-1:0] s1_cos_q, s1_cos_d;

  logic                  s2_vld_q, s2_vld_d;
  logic signed [PW-1:0]  s2_pi_q, s2_pi_d;
  logic signed [PW-1:0]  s2_pq_q, s2_pq_d;

  logic                  o_vld_q, o_vld_d;
  logic signed [OW-1:0]  i_q, i_d;
  logic signed [OW-1:0]  q_q, q_d;
  logic                  sat_q, sat_d;
  logic [CW-1:0]         drop_q, drop_d;

  logic signed [PW-1:0]  smp_x;
  logic signed [PW-1:0]  sin_x;
  logic signed [PW-1:0]  cos_x;

  logic signed [OW-1:0]  ri_c, rq_c;
  logic                  sati_c, satq_c;

  // Stage-3 round/saturate, one instance per channel.
  nco_round_sat #(.IW(PW), .S(S), .OW(OW)) u_rs_i (
    .din   (s2_pi_q),
    .res_c (ri_c),
    .sat_c (sati_c)
  );

  nco_round_sat #(.IW(PW), .S(S), .OW(OW)) u_rs_q (
    .din   (s2_pq_q),
    .res_c (rq_c),
    .sat_c (satq_c)
  );

  // Next-state for pipeline, counters and sticky flag.
  always_comb begin
    accept_c = clken & in_valid & nco_valid;
    drop_c   = clken & in_valid & ~nco_valid;

    s1_vld_d = s1_vld_q;
    s1_smp_d = s1_smp_q;
    s1_sin_d = s1_sin_q;
    s1_cos_d = s1_cos_q;
    s2_vld_d = s2_vld_q;
    s2_pi_d  = s2_pi_q;
    s2_pq_d  = s2_pq_q;
    o_vld_d  = o_vld_q;
    i_d      = i_q;
    q_d      = q_q;

    // Sign-extend to the product width so the multiply is exact.
    smp_x = PW'(s1_smp_q);
    sin_x = PW'(s1_sin_q);
    cos_x = PW'(s1_cos_q);

    if (clken) begin
      s1_vld_d = accept_c;
      s2_vld_d = s1_vld_q;
      o_vld_d  = s2_vld_q;
      if (accept_c) begin
        s1_smp_d = sample_i;
        s1_sin_d = fsin_i;
        s1_cos_d = fcos_i;
      end
      if (s1_vld_q) begin
        s2_pi_d = smp_x * cos_x;
        s2_pq_d = -(smp_x * sin_x);
      end
      if (s2_vld_q) begin
        i_d = ri_c;
        q_d = rq_c;
      end
    end

    drop_d = drop_q;
    if (drop_c && (drop_q != '1)) begin
      drop_d = drop_q + CW'(1);
    end

    // Clear first so a simultaneous new saturation wins.
    sat_d = sat_q;
    if (sat_clr) begin
      sat_d = 1'b0;
    end
    if (clken && s2_vld_q && (sati_c || satq_c)) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q <= 1'b0;
      s1_smp_q <= '0;
      s1_sin_q <= '0;
      s1_cos_q <= '0;
      s2_vld_q <= 1'b0;
      s2_pi_q  <= '0;
      s2_pq_q  <= '0;
      o_vld_q  <= 1'b0;
      i_q      <= '0;
      q_q      <= '0;
      sat_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_smp_q <= s1_smp_d;
      s1_sin_q <= s1_sin_d;
      s1_cos_q <= s1_cos_d;
      s2_vld_q <= s2_vld_d;
      s2_pi_q  <= s2_pi_d;
      s2_pq_q  <= s2_pq_d;
      o_vld_q  <= o_vld_d;
      i_q      <= i_d;
      q_q      <= q_d;
      sat_q    <= sat_d;
      drop_q   <= drop_d;
    end
  end

  // The valid flag is held while disabled; gating with clken keeps the pulse
  // visible in exactly one enabled cycle and never while clken is low.
  assign out_valid = o_vld_q & clken;
  assign i_o       = i_q;
  assign q_o       = q_q;
  assign sat_flag  = sat_q;
  assign drop_cnt  = drop_q;

endmodule
